// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings, width limits
// and the maximal-length Galois LFSR tap table.
package led_pattern_pkg;

  typedef enum logic [2:0] {
    MODE_COUNT  = 3'd0,
    MODE_BOUNCE = 3'd1,
    MODE_LFSR   = 3'd2,
    MODE_ALT    = 3'd3,
    MODE_BAR    = 3'd4,
    MODE_ROTATE = 3'd5,
    MODE_HOLD6  = 3'd6,
    MODE_HOLD7  = 3'd7
  } mode_e;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 16;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [15:0] ALT_INIT_16 = 16'h5555;

  // Right-shifting Galois masks: bit (t-1) set for every tap t of the polynomial.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] mask;
    case (width)
      4:       mask = 16'h000C;
      5:       mask = 16'h0014;
      6:       mask = 16'h0030;
      7:       mask = 16'h0060;
      8:       mask = 16'h00B8;
      9:       mask = 16'h0110;
      10:      mask = 16'h0240;
      11:      mask = 16'h0500;
      12:      mask = 16'h0E08;
      13:      mask = 16'h1C80;
      14:      mask = 16'h3802;
      15:      mask = 16'h6000;
      16:      mask = 16'hD008;
      default: mask = 16'h0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/led_pattern_engine_prescaler.sv
// Step-rate prescaler: one tick every speed+1 enabled cycles, clearable on a
// mode change.
module led_prescaler
  import led_pattern_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] speed,
  output logic               tick
);

  logic [PRESC_W-1:0] count_q;
  logic [PRESC_W-1:0] count_d;
  logic               wrap_s;

  // Comparing with >= lets a lowered speed fire on the very next enabled cycle.
  always_comb begin
    wrap_s  = (count_q >= speed);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wrap_s) begin
      count_d = '0;
    end else begin
      count_d = count_q + PRESC_W'(1);
    end
  end

  // Counter state, frozen while the engine is disabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_d;
    end
  end

  assign tick = enable & ~clear & wrap_s;

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: prescaled pattern generator with selectable modes and a
// 16-level PWM brightness gate on the registered LED outputs.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [2:0]         mode,
  input  logic [PRESC_W-1:0] speed,
  input  logic [3:0]         brightness,
  output logic [WIDTH-1:0]   led_out,
  output logic               step
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("led_pattern_engine: WIDTH must lie in 4..16");
  end

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] ALT_INIT = WIDTH'(ALT_INIT_16);

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  mode_e            mode_q;
  mode_e            mode_in_s;
  logic [WIDTH-1:0] pattern_q, pattern_d, pattern_adv_s, pattern_init_s;
  logic             dir_q, dir_d, dir_adv_s;
  logic [3:0]       pwm_q;
  logic [WIDTH-1:0] led_q;
  logic             step_q;
  logic             mode_chg_s;
  logic             tick_s;
  logic             pwm_on_s;

  assign mode_in_s  = mode_e'(mode);
  assign mode_chg_s = (mode_in_s != mode_q);

  led_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .clear   (mode_chg_s),
    .speed   (speed),
    .tick    (tick_s)
  );

  // One advance of the pattern under the currently registered mode.
  always_comb begin
    pattern_adv_s = pattern_q;
    dir_adv_s     = dir_q;
    case (mode_q)
      MODE_COUNT: pattern_adv_s = pattern_q + ONE;
      MODE_BOUNCE: begin
        if (!is_onehot(pattern_q)) begin
          pattern_adv_s = ONE;
          dir_adv_s     = DIR_LEFT;
        end else if (dir_q == DIR_LEFT) begin
          if (pattern_q[WIDTH-1]) begin
            pattern_adv_s = pattern_q >> 1;
            dir_adv_s     = DIR_RIGHT;
          end else begin
            pattern_adv_s = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            pattern_adv_s = pattern_q << 1;
            dir_adv_s     = DIR_LEFT;
          end else begin
            pattern_adv_s = pattern_q >> 1;
          end
        end
      end
      MODE_LFSR: begin
        if (pattern_q == '0) begin
          pattern_adv_s = ONE;
        end else begin
          pattern_adv_s = (pattern_q >> 1) ^ (pattern_q[0] ? TAPS : '0);
        end
      end
      MODE_ALT: pattern_adv_s = ~pattern_q;
      MODE_BAR: begin
        // Fill phase keeps bit0 set; the drain phase is recognised by bit0 clear.
        if (pattern_q == ALL_ONES) begin
          pattern_adv_s = {pattern_q[WIDTH-2:0], 1'b0};
        end else if (pattern_q[0] || (pattern_q == '0)) begin
          pattern_adv_s = {pattern_q[WIDTH-2:0], 1'b1};
        end else begin
          pattern_adv_s = {pattern_q[WIDTH-2:0], 1'b0};
        end
      end
      MODE_ROTATE: pattern_adv_s = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
      default:     pattern_adv_s = '0;
    endcase
  end

  // Starting pattern of the incoming mode.
  always_comb begin
    pattern_init_s = '0;
    case (mode_in_s)
      MODE_BOUNCE, MODE_LFSR, MODE_ROTATE: pattern_init_s = ONE;
      MODE_ALT:                            pattern_init_s = ALT_INIT;
      default:                             pattern_init_s = '0;
    endcase
  end

  // Mode change outranks a coincident tick.
  always_comb begin
    pattern_d = pattern_q;
    dir_d     = dir_q;
    if (mode_chg_s) begin
      pattern_d = pattern_init_s;
      dir_d     = DIR_LEFT;
    end else if (tick_s) begin
      pattern_d = pattern_adv_s;
      dir_d     = dir_adv_s;
    end else begin
      pattern_d = pattern_q;
      dir_d     = dir_q;
    end
  end

  assign pwm_on_s = (brightness == 4'd15) || (pwm_q < brightness);

  // Engine state and registered outputs; everything freezes while disabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= MODE_COUNT;
      pattern_q <= '0;
      dir_q     <= DIR_LEFT;
      pwm_q     <= 4'd0;
      led_q     <= '0;
      step_q    <= 1'b0;
    end else if (enable) begin
      mode_q    <= mode_in_s;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      pwm_q     <= pwm_q + 4'd1;
      led_q     <= pattern_q & {WIDTH{pwm_on_s}};
      step_q    <= tick_s;
    end else begin
      step_q    <= 1'b0;
    end
  end

  assign led_out = led_q;
  assign step    = step_q;

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH      8   LED count; legal 4..16
  PRESC_W    16  prescaler width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock       in   1        single system clock; all state on rising edge
  reset_n     in   1        asynchronous, active-low reset
  enable      in   1        global run enable; low freezes all state
  mode        in   3        pattern select (see REQ-010)
  speed       in   PRESC_W  step period = speed+1 enabled cycles
  brightness  in   4        PWM duty, 0 = off, 15 = full
  led_out     out  WIDTH    registered LED drive
  step        out  1        registered one-cycle strobe on each pattern advance
REQ-003 There SHALL be one clock and one asynchronous, active-low reset; no other clocks or resets.

Function
REQ-004 Enable gating: with enable low, prescaler, PWM counter, pattern, direction, mode register, led_out and step SHALL all hold; step SHALL read 0.
REQ-005 Prescaler: when count >= speed, a tick SHALL fire and count SHALL return to 0; otherwise count+1. Lowering speed below count SHALL tick on the next enabled cycle.
REQ-006 On a tick the pattern SHALL advance one step per the active mode; step SHALL be 1 in the following cycle.
REQ-007 Mode change: mode SHALL be registered each enabled cycle; when the input differs from the register, pattern SHALL load the new mode's initial value, direction SHALL reset to left, prescaler SHALL clear, and no advance SHALL occur that cycle.
REQ-008 Mode change takes priority over a coincident tick.
REQ-009 The bouncing scanner SHALL use an explicit direction bit; all-zero or multi-hot patterns SHALL NOT be reachable in that mode.
REQ-010 Modes (initial value; step rule):
  0 count:   0; pattern+1 modulo 2^WIDTH, all-ones wraps to 0
  1 bounce:  bit0; shift toward the current direction, reversing at bit WIDTH-1 and bit0, so endpoints are visited once per sweep
  2 lfsr:    1; maximal-length Galois LFSR using the package tap table; a zero state SHALL be forced to 1
  3 alt:     0101..b; bitwise invert
  4 bar:     0; fill from bit0 (shift left, insert 1) until all-ones, then drain (shift left, insert 0) until zero, repeat
  5 rotate:  bit0; rotate left by 1
  6,7:       0; hold at 0
REQ-011 PWM: a 4-bit counter SHALL increment every enabled cycle and wrap 15->0; pwm_on = (brightness==15) or (pwm_cnt < brightness).
REQ-012 led_out SHALL be registered as pattern AND {WIDTH{pwm_on}}; pattern changes appear at led_out one cycle after the advance.
REQ-013 Brightness and speed changes SHALL take effect on the next enabled cycle with no pattern reset.

Reset
REQ-014 While reset_n is low: led_out=0, step=0, pattern=0, direction=left, prescaler=0, pwm_cnt=0, mode register=0.
REQ-015 Reset SHALL act mid-sweep, mid-tick or mid-PWM period with no residual state.
REQ-016 After release, the first enabled cycle with mode != 0 SHALL be treated as a mode change (REQ-007).

Structure
REQ-017 A shared package led_pattern_pkg SHALL hold the mode encodings (3-bit enum) and the LFSR tap-mask function/table for WIDTH 4..16.
REQ-018 The prescaler SHALL be a sub-module named led_prescaler (inputs clock, reset_n, enable, clear, speed; output tick).
REQ-019 An illegal WIDTH SHALL fail elaboration.

Verification
REQ-020 WIDTH=8, mode=0, speed=3, brightness=15: pattern steps every 4 cycles; 0xFF -> 0x00 wrap; step pulses one cycle per advance.
REQ-021 Mode=1, speed=0: led_out sequence 01,02,04,...,80,40,...,01,02, with 14 steps per full period, one-hot throughout.
REQ-022 Mode=2 from reset: 255 distinct nonzero states before repeat; a forced zero state recovers to 0x01.
REQ-023 Mode=5, brightness=4: led_out nonzero exactly 4 of every 16 enabled cycles; brightness=0 gives led_out=0 constantly.
REQ-024 Switch mode 0->4 coincident with a tick: pattern=0, no advance, prescaler cleared; then 01,03,...,FF,FE,...,00.
REQ-025 Assert reset_n low mid-sweep and toggle enable low mid-period: all outputs 0 during reset; state frozen while enable is low; resumes exactly where it stopped.
